// File: rtl/calc_exec_ctrl.sv
// Execution sequencer for the keypad calculator: captures BCD operands, runs add/sub/
// shift-add multiply, converts the binary result to four BCD digits via double-dabble.
module calc_exec_ctrl #(
  parameter int BIN_W = 14,
  parameter int OPR_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] a_tens,
  input  logic [3:0] a_ones,
  input  logic [3:0] b_tens,
  input  logic [3:0] b_ones,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       neg,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} state_t;

  localparam int CW = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic [3:0]         cap_at, cap_ao, cap_bt, cap_bo;
  logic [1:0]         cap_op;
  logic [BIN_W-1:0]   mcand;
  logic [OPR_W-1:0]   mplier;
  logic [BIN_W-1:0]   r;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [15:0]        conv_next;
  logic [15:0]        res;
  logic               neg_pend;
  logic [CW-1:0]      cnt;
  logic               bad;
  logic [OPR_W-1:0]   a_val, b_val;

  always_comb begin
    bad   = (cap_at > 4'd9) || (cap_ao > 4'd9) || (cap_bt > 4'd9) ||
            (cap_bo > 4'd9) || (cap_op == 2'd3);
    a_val = OPR_W'(cap_at) * OPR_W'(10) + OPR_W'(cap_ao);
    b_val = OPR_W'(cap_bt) * OPR_W'(10) + OPR_W'(cap_bo);
  end

  // Double-dabble step: add 3 to any nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    conv_next = {bcd_adj[14:0], r[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = bad ? DONE : EXEC;
      EXEC: if (cap_op != 2'd2 || cnt == CW'(OPR_W - 1)) state_nxt = CONV;
      CONV: if (cnt == CW'(BIN_W - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_at   <= '0;
      cap_ao   <= '0;
      cap_bt   <= '0;
      cap_bo   <= '0;
      cap_op   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      r        <= '0;
      bcd      <= '0;
      neg_pend <= 1'b0;
      cnt      <= '0;
      res      <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cap_at <= a_tens;
          cap_ao <= a_ones;
          cap_bt <= b_tens;
          cap_bo <= b_ones;
          cap_op <= op;
        end
        LOAD: begin
          mcand    <= BIN_W'(a_val);
          mplier   <= b_val;
          r        <= '0;
          bcd      <= '0;
          neg_pend <= 1'b0;
          cnt      <= '0;
        end
        EXEC: begin
          case (cap_op)
            2'd0: r <= mcand + BIN_W'(mplier);
            2'd1: begin
              if (mcand < BIN_W'(mplier)) begin
                r        <= BIN_W'(mplier) - mcand;
                neg_pend <= 1'b1;
              end else begin
                r <= mcand - BIN_W'(mplier);
              end
            end
            default: begin
              r      <= r + (mplier[0] ? mcand : '0);
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          endcase
          cnt <= (state_nxt == CONV) ? '0 : cnt + CW'(1);
        end
        CONV: begin
          bcd <= conv_next;
          r   <= r << 1;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
      // Results land on the edge entering DONE; abort never gets here.
      if (state_nxt == DONE && state != DONE) begin
        if (state == LOAD) begin
          res <= '0;
          neg <= 1'b0;
          err <= 1'b1;
        end else begin
          res <= conv_next;
          neg <= neg_pend;
          err <= 1'b0;
        end
      end
    end
  end

  assign d3 = res[15:12];
  assign d2 = res[11:8];
  assign d1 = res[7:4];
  assign d0 = res[3:0];

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Bench for calc_exec_ctrl: directed plan items plus random requests checked against
// an arithmetic reference model (decimal digits, latency by op class).
module tb_calc_exec_ctrl;

  localparam int BIN_W = 14;
  localparam int OPR_W = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] a_tens = '0, a_ones = '0, b_tens = '0, b_ones = '0;
  logic [1:0] op = '0;
  logic       busy, done, neg, err;
  logic [3:0] d3, d2, d1, d0;

  int checks = 0;
  int passed = 0;

  logic [15:0] prev_d = '0;
  logic        prev_n = 1'b0;
  logic        prev_e = 1'b0;

  calc_exec_ctrl #(.BIN_W(BIN_W), .OPR_W(OPR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_tens(a_tens), .a_ones(a_ones), .b_tens(b_tens), .b_ones(b_ones),
    .op(op), .busy(busy), .done(done),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic void model(input int at, input int ao, input int bt, input int bo,
                                input int o, output logic [15:0] ed, output logic en,
                                output logic ee, output int el);
    int a, b, v;
    ed = '0; en = 1'b0; ee = 1'b0;
    if (at > 9 || ao > 9 || bt > 9 || bo > 9 || o == 3) begin
      ee = 1'b1;
      el = 1;
      return;
    end
    a = at * 10 + ao;
    b = bt * 10 + bo;
    case (o)
      0: v = a + b;
      1: begin v = (a >= b) ? a - b : b - a; en = (a < b); end
      default: v = a * b;
    endcase
    ed = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    el = (o == 2) ? 1 + OPR_W + BIN_W : 2 + BIN_W;
  endfunction

  task automatic do_req(input int at, input int ao, input int bt, input int bo,
                        input int o, input bit perturb, input bit with_abort);
    logic [15:0] ed;
    logic        en, ee;
    int          el, lat;
    bit          got;
    model(at, ao, bt, bo, o, ed, en, ee, el);
    @(negedge clk);
    a_tens = 4'(at); a_ones = 4'(ao); b_tens = 4'(bt); b_ones = 4'(bo);
    op = 2'(o); start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done) got = 1'b1;
      else if (!busy) chk("busy_drop", 32'(busy), 32'd1);
      if (perturb) begin
        start = 1'($urandom);
        a_tens = 4'($urandom); a_ones = 4'($urandom);
        b_tens = 4'($urandom); b_ones = 4'($urandom); op = 2'($urandom);
      end
    end
    chk("latency", got ? lat : -1, el);
    chk("digits", {d3, d2, d1, d0}, ed);
    chk("neg", neg, en);
    chk("err", err, ee);
    prev_d = ed; prev_n = en; prev_e = ee;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic check_cleared(input string tag);
    chk(tag, {busy, done, d3, d2, d1, d0, neg, err}, '0);
  endtask

  initial begin
    int n_done;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    rst_n = 1'b1;

    do_req(1, 2, 3, 4, 0, 1'b0, 1'b0);  // 0046
    do_req(1, 2, 3, 4, 1, 1'b0, 1'b0);  // 0022 neg
    do_req(0, 5, 0, 5, 1, 1'b0, 1'b0);  // 0000 pos
    do_req(9, 9, 9, 9, 2, 1'b0, 1'b0);  // 9801
    do_req(0, 0, 5, 7, 2, 1'b0, 1'b0);
    do_req(1, 10, 3, 4, 0, 1'b0, 1'b0); // bad digit
    do_req(1, 2, 3, 4, 3, 1'b0, 1'b0);  // reserved op
    do_req(4, 2, 1, 7, 0, 1'b0, 1'b1);  // abort+start in IDLE, start wins
    do_req(3, 8, 2, 6, 2, 1'b1, 1'b0);  // start/operand noise mid-run

    // Abort at E0+5: back to IDLE, no done, previous result kept.
    @(negedge clk);
    a_tens = 4'd5; a_ones = 4'd5; b_tens = 4'd4; b_ones = 4'd4; op = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_keep", {d3, d2, d1, d0, neg, err}, {prev_d, prev_n, prev_e});
    n_done = 0;
    repeat (25) begin @(posedge clk); #1; if (done) n_done++; end
    chk("abort_no_done", n_done, 0);

    // Reset asserted for one edge during CONV.
    @(negedge clk);
    a_tens = 4'd7; a_ones = 4'd1; b_tens = 4'd2; b_ones = 4'd9; op = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_cleared("midrun_reset");
    n_done = 0;
    repeat (25) begin @(posedge clk); #1; if (done) n_done++; end
    chk("reset_no_done", n_done, 0);
    do_req(7, 1, 2, 9, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int at, ao, bt, bo;
      at = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      ao = $urandom_range(0, 9);
      bt = $urandom_range(0, 9);
      bo = $urandom_range(0, 9);
      do_req(at, ao, bt, bo, $urandom_range(0, 3), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
